// File: rtl/vga_fifo_loader.sv
// PIO-fed word FIFO that unpacks 32-bit words into PIXEL_W-bit pixels for the VGA stage.
// Writes are signalled by level changes on pio_wr_toggle; status flags pace software writes.
module vga_fifo_loader #(
    parameter int DEPTH_LOG2 = 4,
    parameter int PIXEL_W    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        pio_data,
    input  logic               pio_wr_toggle,
    input  logic               clear,
    input  logic               pixel_req,
    output logic [PIXEL_W-1:0] pixel_data,
    output logic               pixel_valid,
    output logic [DEPTH_LOG2:0] fifo_level,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic               overflow,
    output logic               underflow
);

    localparam int DEPTH        = 1 << DEPTH_LOG2;
    localparam int LVL_W        = DEPTH_LOG2 + 1;
    localparam int PIX_PER_WORD = 32 / PIXEL_W;
    localparam int IDX_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(PIX_PER_WORD - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [LVL_W-1:0]      FULL_LVL = LVL_W'(DEPTH);

    logic [31:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [IDX_W-1:0]      r_pix_idx;
    logic [LVL_W-1:0]      r_level;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  r_tog_q;
    logic [PIXEL_W-1:0]    r_pix_data_p1;
    logic                  r_vld_p1;

    logic                  w_wr_evt;
    logic                  w_push;
    logic                  w_rd_ok;
    logic                  w_pop;
    logic [31:0]           w_head;
    logic [PIXEL_W-1:0]    w_pix;
    logic [LVL_W-1:0]      w_level_nxt;

    // Full/empty decisions use the start-of-cycle registered level, so a
    // same-cycle pop never makes room for a push into a full FIFO.
    always_comb begin
        w_wr_evt    = pio_wr_toggle ^ r_tog_q;
        w_push      = w_wr_evt && !r_full && !clear;
        w_rd_ok     = pixel_req && !r_empty && !clear;
        w_pop       = w_rd_ok && (r_pix_idx == LAST_IDX);
        w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        w_head      = r_mem[r_rd_ptr];
    end

    always_comb begin
        w_pix = '0;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (r_pix_idx == IDX_W'(i)) w_pix = w_head[i*PIXEL_W +: PIXEL_W];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= pio_data;
    end

    // Stage p0 -> p1: control state and registered pixel output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tog_q       <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_pix_idx     <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_ovf         <= 1'b0;
            r_udf         <= 1'b0;
            r_vld_p1      <= 1'b0;
            r_pix_data_p1 <= '0;
        end else begin
            r_tog_q <= pio_wr_toggle;
            if (clear) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_pix_idx <= '0;
                r_level   <= '0;
                r_full    <= 1'b0;
                r_empty   <= 1'b1;
                r_ovf     <= 1'b0;
                r_udf     <= 1'b0;
                r_vld_p1  <= 1'b0;
            end else begin
                r_level  <= w_level_nxt;
                r_full   <= (w_level_nxt == FULL_LVL);
                r_empty  <= (w_level_nxt == '0);
                r_vld_p1 <= w_rd_ok;
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
                if (w_wr_evt && r_full) r_ovf <= 1'b1;
                if (w_rd_ok) begin
                    r_pix_data_p1 <= w_pix;
                    r_pix_idx     <= w_pop ? '0 : r_pix_idx + IDX_ONE;
                end else if (pixel_req) begin
                    r_pix_data_p1 <= '0;
                    r_udf         <= 1'b1;
                end
            end
        end
    end

    assign pixel_data  = r_pix_data_p1;
    assign pixel_valid = r_vld_p1;
    assign fifo_level  = r_level;
    assign fifo_full   = r_full;
    assign fifo_empty  = r_empty;
    assign overflow    = r_ovf;
    assign underflow   = r_udf;

endmodule

// File: tb/tb_vga_fifo_loader.sv
// Directed bench for vga_fifo_loader: a vector table for single-word/underflow/clear
// behaviour plus hand sequences for overflow, same-cycle push/pop, wrap-around and reset.
module tb_vga_fifo_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pio_data = '0;
    logic        pio_wr_toggle = 1'b0;
    logic        clear = 1'b0;
    logic        pixel_req = 1'b0;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic [4:0]  fifo_level;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_fifo_loader #(.DEPTH_LOG2(4), .PIXEL_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .pio_data(pio_data), .pio_wr_toggle(pio_wr_toggle),
        .clear(clear), .pixel_req(pixel_req), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .overflow(overflow), .underflow(underflow)
    );

    typedef struct {
        logic        flip;
        logic [31:0] data;
        logic        req;
        logic        clr;
        logic        e_vld;
        logic [15:0] e_pd;
        logic [4:0]  e_lvl;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input logic [4:0] lvl, input logic ovf, input logic udf);
        chk({name, ".level"}, 32'(fifo_level), 32'(lvl));
        chk({name, ".full"}, 32'(fifo_full), 32'(lvl == 5'd16));
        chk({name, ".empty"}, 32'(fifo_empty), 32'(lvl == 5'd0));
        chk({name, ".overflow"}, 32'(overflow), 32'(ovf));
        chk({name, ".underflow"}, 32'(underflow), 32'(udf));
    endtask

    task automatic chk_pix(input string name, input logic vld, input logic [15:0] pd);
        chk({name, ".valid"}, 32'(pixel_valid), 32'(vld));
        chk({name, ".data"}, 32'(pixel_data), 32'(pd));
    endtask

    // One clock: drive inputs, take the edge, then sample 1 time unit later.
    task automatic cyc(input logic flip, input logic [31:0] d, input logic req, input logic clr);
        if (flip) pio_wr_toggle = ~pio_wr_toggle;
        pio_data  = d;
        pixel_req = req;
        clear     = clr;
        @(posedge clk);
        #1;
        pixel_req = 1'b0;
        clear     = 1'b0;
    endtask

    function automatic logic [31:0] wd(input int i);
        return {16'(i + 256), 16'(i)};
    endfunction

    task automatic drain_word(input string name, input logic [31:0] w);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_pix({name, ".lo"}, 1'b1, w[15:0]);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_pix({name, ".hi"}, 1'b1, w[31:16]);
    endtask

    initial begin
        logic [31:0] w;
        int          seq;

        tv[0]  = '{1'b1, 32'hAAAA5555, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 16'h5555, 5'd1, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 16'hAAAA, 5'd0, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'hAAAA, 5'd0, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b1};
        tv[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b1};
        tv[7]  = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b1};
        tv[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 16'h5678, 5'd1, 1'b0, 1'b1};
        tv[9]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 16'h5678, 5'd0, 1'b0, 1'b0};
        tv[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'h5678, 5'd0, 1'b0, 1'b0};
        tv[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b1};
        tv[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_pix("reset", 1'b0, 16'h0000);
        chk_status("reset", 5'd0, 1'b0, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cyc(tv[i].flip, tv[i].data, tv[i].req, tv[i].clr);
            chk_pix($sformatf("vec%0d", i), tv[i].e_vld, tv[i].e_pd);
            chk_status($sformatf("vec%0d", i), tv[i].e_lvl, tv[i].e_ovf, tv[i].e_udf);
        end

        // 17 pushes into a 16-deep FIFO
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, wd(i), 1'b0, 1'b0);
            if (i == 15) chk_status("fill16", 5'd16, 1'b0, 1'b0);
        end
        chk_status("fill17", 5'd16, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) drain_word($sformatf("ovf_drain%0d", i), wd(i));
        chk_status("ovf_drained", 5'd0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_pix("ovf_after", 1'b0, 16'h0000);
        chk_status("ovf_after", 5'd0, 1'b1, 1'b1);

        // Push on final-pixel pop while full: pop happens, push dropped
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b1, wd(100 + i), 1'b0, 1'b0);
        w = wd(100);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_pix("fullpop.lo", 1'b1, w[15:0]);
        cyc(1'b1, 32'hFFFF0000, 1'b1, 1'b0);
        chk_pix("fullpop.hi", 1'b1, w[31:16]);
        chk_status("fullpop", 5'd15, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) drain_word($sformatf("fullpop_drain%0d", i), wd(100 + i));
        chk_status("fullpop_drained", 5'd0, 1'b1, 1'b0);

        // Same situation at level 8: push and pop both happen
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, wd(200 + i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, wd(300), 1'b1, 1'b0);
        w = wd(200);
        chk_pix("midpop.hi", 1'b1, w[31:16]);
        chk_status("midpop", 5'd8, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) drain_word($sformatf("midpop_drain%0d", i), wd(200 + i));
        drain_word("midpop_drain_new", wd(300));
        chk_status("midpop_drained", 5'd0, 1'b0, 1'b0);

        // Wrap-around: 40 rounds of 3 pushes then full drain
        cyc(1'b0, '0, 1'b0, 1'b1);
        seq = 1000;
        for (int r = 0; r < 40; r++) begin
            for (int j = 0; j < 3; j++) cyc(1'b1, wd(seq + j), 1'b0, 1'b0);
            chk(.name($sformatf("wrap%0d.level3", r)), .act(32'(fifo_level)), .exp(32'd3));
            for (int j = 0; j < 3; j++) drain_word($sformatf("wrap%0d_%0d", r, j), wd(seq + j));
            chk(.name($sformatf("wrap%0d.level0", r)), .act(32'(fifo_level)), .exp(32'd0));
            seq += 3;
        end

        // Reset mid-operation at level 5, pix_idx=1, with overflow set beforehand
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) cyc(1'b1, wd(500 + i), 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) drain_word($sformatf("pre_rst%0d", i), wd(500 + i));
        w = wd(511);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_pix("pre_rst.lo", 1'b1, w[15:0]);
        chk_status("pre_rst", 5'd5, 1'b1, 1'b0);
        #2;
        reset_n       = 1'b0;
        pio_wr_toggle = 1'b0;
        #1;
        chk_pix("async_rst", 1'b0, 16'h0000);
        chk_status("async_rst", 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(1'b1, 32'hBEEFCAFE, 1'b0, 1'b0);
        chk_status("post_rst_push", 5'd1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_pix("post_rst_pix", 1'b1, 16'hCAFE);
        chk_status("post_rst_pix", 5'd1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
